mux_rr_scheduler: RTL and testbench
===================================

Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the registered N:1 PE output multiplexer between NUM_PES requesting PEs.
- Picks one requesting PE and drives the mux select from a register.
- Tracks the mux's one-cycle register latency and presents a valid/ready handshake to the downstream consumer, aligned with the mux output.
- Acknowledges the served PE with a one-cycle grant pulse when the downstream consumer accepts its word.

Parameters:
- NUM_PES, 16: number of requesting PEs and mux inputs.
- NUM_SEL, $clog2(NUM_PES): width of the select and PE-index fields.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  NUM_PES  per-PE request. A PE holds req and its mux data stable until it sees its grant bit.
- out_ready  input  1  downstream consumer can accept the mux output this cycle.
- sel  output  NUM_SEL  registered select, wired to the mux sel_in.
- out_valid  output  1  mux data_out holds the word of PE out_pe.
- out_pe  output  NUM_SEL  index of the PE currently being served (equals sel).
- grant  output  NUM_PES  one-hot, one-cycle pulse on the cycle the transfer completes (out_valid && out_ready).
- busy  output  1  high in FILL or VALID.
- xfer_count  output  CNT_W  number of completed transfers since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, sel=0, out_pe=0, rr_ptr=0, xfer_count=0.
  - out_valid=0, grant=0, busy=0.
  - Reset has priority over every other event, including mid-transfer. An in-flight transfer is dropped with no grant. The affected PE keeps req high and is re-served after reset.
- Round-robin pick:
  - Search order is rr_ptr, rr_ptr+1, ..., modulo NUM_PES. The first set bit of the candidate vector wins.
  - rr_ptr updates to (winner+1) mod NUM_PES only on transfer completion.
- FSM states: IDLE, FILL, VALID.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise register sel=out_pe=winner over req, then go to FILL.
- FILL (exactly 1 cycle):
  - The mux register captures data_in for the new sel.
  - out_valid=0. Go to VALID.
- VALID:
  - out_valid=1, and sel is held stable. Because the mux reloads every cycle from the stable PE data, data_out stays constant through a stall.
  - If out_ready=0, stay in VALID with no grant.
  - If out_ready=1 (transfer completes):
    - grant[out_pe]=1 for this cycle; xfer_count increments; rr_ptr=out_pe+1.
    - The next winner is picked over candidates = req with bit out_pe masked, since the served PE's req is still high this cycle.
    - If candidates!=0: load the new sel and go to FILL.
    - Otherwise go to IDLE.
- Latency and throughput:
  - First request in IDLE to out_valid takes 2 cycles (IDLE->FILL->VALID).
  - Sustained throughput is 1 word per 2 cycles: FILL always separates consecutive words.
- Fairness: with all PEs requesting continuously, service order is 0,1,...,NUM_PES-1,0,... Worst-case wait is (NUM_PES-1) transfers.
- Boundaries:
  - A single PE requesting back-to-back is served once per request. The served PE's req must fall in the cycle after its grant; a re-assertion is seen in the next IDLE pick.
  - A req bit rising during FILL or VALID is considered at the next pick, never preempting the current transfer.
  - Dropping req before grant is a protocol violation. The scheduler still completes the current transfer.
  - When the winner is NUM_PES-1, rr_ptr wraps to 0.
  - xfer_count wraps from 2^CNT_W-1 to 0 without a flag.
  - grant is never asserted when out_valid=0.

Decomposition:
- Shared package mux_sched_pkg holds:
  - state enum {IDLE, FILL, VALID} (2-bit encoding).
  - localparam NUM_SEL derivation.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: candidate vector, rr_ptr. Outputs: winner index, any-valid.
  - Implemented as a double-width rotate and priority encode, so it can be reused by other PE arbiters.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 for 10 cycles -> out_valid=0, grant=0, busy=0, sel=0, xfer_count=0 throughout.
- Single request: req=16'h0020, out_ready=1 -> sel=5 one cycle later, out_valid=1 two cycles later. At that cycle grant=16'h0020 and data_out equals PE5's word. xfer_count=1, rr_ptr=6.
- Full contention: req=16'hFFFF held, out_ready=1 -> grants in order PE0..PE15, then PE0 again, one grant every 2 cycles. xfer_count=17 after 34 cycles of service.
- Backpressure: PE3 in VALID with out_ready=0 for 5 cycles -> out_valid held, sel=3, data_out constant, no grant. On out_ready=1, grant=16'h0008 for exactly one cycle.
- Pointer wrap and masking: rr_ptr=15, req=16'h8001 -> PE15 served first, then PE0. Next pick excludes PE15 even though its req is still high on the grant cycle.
- Reset mid-transfer: rst=1 while in VALID serving PE7 -> no grant, out_valid=0 next cycle, rr_ptr=0. With req=16'h0080 still high after reset, PE7 is served again.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared types and default sizing for the PE output-mux scheduler and its arbiters.
package mux_sched_pkg;

  localparam int unsigned DEF_NUM_PES = 16;
  localparam int unsigned DEF_NUM_SEL = $clog2(DEF_NUM_PES);
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    VALID = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set candidate at or after ptr, modulo N.
module rr_pick #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   offs;
  logic [W:0]     sum;

  // Rotate so ptr lands on bit 0, then priority-encode the lowest set bit.
  always_comb begin
    dbl  = {cand, cand} >> ptr;
    rot  = dbl[N-1:0];
    offs = '0;
    any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offs = W'(i);
        any  = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, offs};
    if (sum >= (W+1)'(N)) begin
      sum = sum - (W+1)'(N);
    end
    winner = sum[W-1:0];
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the registered N:1 PE output mux; tracks the mux register
// latency and exposes a valid/ready handshake aligned with the mux output.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int unsigned NUM_PES = DEF_NUM_PES,
  parameter int unsigned NUM_SEL = $clog2(NUM_PES),
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PES-1:0] req,
  input  logic               out_ready,
  output logic [NUM_SEL-1:0] sel,
  output logic               out_valid,
  output logic [NUM_SEL-1:0] out_pe,
  output logic [NUM_PES-1:0] grant,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_count
);

  state_t               state_q, state_d;
  logic [NUM_SEL-1:0]   sel_q, sel_d;
  logic [NUM_SEL-1:0]   rr_ptr_q;
  logic                 out_valid_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 in_valid;
  logic                 done;
  logic [NUM_PES-1:0]   served_oh;
  logic [NUM_PES-1:0]   cand;
  logic [NUM_SEL-1:0]   ptr_inc;
  logic [NUM_SEL-1:0]   pick_ptr;
  logic [NUM_SEL-1:0]   winner;
  logic                 any;

  assign in_valid  = (state_q == VALID);
  assign done      = in_valid && out_ready && !rst;
  assign served_oh = NUM_PES'(1) << sel_q;
  assign ptr_inc   = (sel_q == NUM_SEL'(NUM_PES - 1)) ? '0 : sel_q + NUM_SEL'(1);

  // On completion the served PE still holds req, so mask it and search from out_pe+1.
  assign cand     = in_valid ? (req & ~served_oh) : req;
  assign pick_ptr = in_valid ? ptr_inc : rr_ptr_q;

  rr_pick #(
    .N (NUM_PES),
    .W (NUM_SEL)
  ) u_rr_pick (
    .cand   (cand),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          sel_d   = winner;
          state_d = FILL;
        end
      end
      FILL: state_d = VALID;
      VALID: begin
        if (out_ready) begin
          if (any) begin
            sel_d   = winner;
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_valid_q <= (state_d == VALID);
      busy_q      <= (state_d != IDLE);
      if (done) begin
        cnt_q    <= cnt_q + CNT_W'(1);
        rr_ptr_q <= ptr_inc;
      end
    end
  end

  // The grant must coincide with the accepting out_ready, so it is decoded, not flopped.
  assign grant      = done ? served_oh : '0;
  assign sel        = sel_q;
  assign out_pe     = sel_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: directed scenarios plus random traffic
// compared every cycle against a transaction-level round-robin model.
module tb_mux_rr_scheduler;

  localparam int unsigned N  = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          out_ready;
  logic [SW-1:0] sel;
  logic          out_valid;
  logic [SW-1:0] out_pe;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] xfer_count;

  mux_rr_scheduler #(.NUM_PES(N), .NUM_SEL(SW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .out_ready  (out_ready),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_pe     (out_pe),
    .grant      (grant),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  // External registered mux fed by per-PE words
  logic [31:0] pe_word [N];
  logic [31:0] mux_q;
  always @(posedge clk) mux_q <= pe_word[sel];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whom the mux is serving and how far along the word is.
  bit          m_busy;
  bit          m_ready_word;
  int          m_pe;
  int          m_ptr;
  logic [CW-1:0] m_cnt;
  logic [N-1:0]  g_last;
  int            gq[$];

  function automatic int pick(input logic [N-1:0] c, input int p);
    for (int k = 0; k < N; k++) begin
      if (c[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic step(input logic [N-1:0] raise, input logic [N-1:0] keep,
                      input logic rdy, input logic r);
    logic [N-1:0] eg;
    logic [N-1:0] c;
    @(posedge clk);
    #1;
    req       = (req & keep & ~g_last) | raise;
    out_ready = rdy;
    rst       = r;
    @(negedge clk);
    eg = (m_ready_word && rdy && !r) ? (N'(1) << m_pe) : '0;
    check("sel", 32'(sel), 32'(m_pe));
    check("out_pe", 32'(out_pe), 32'(m_pe));
    check("out_valid", 32'(out_valid), 32'(m_ready_word));
    check("busy", 32'(busy), 32'(m_busy));
    check("grant", 32'(grant), 32'(eg));
    check("xfer_count", 32'(xfer_count), 32'(m_cnt));
    if (out_valid) check("data_out", mux_q, pe_word[out_pe]);
    g_last = grant;
    for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
    if (r) begin
      m_busy = 0; m_ready_word = 0; m_pe = 0; m_ptr = 0; m_cnt = '0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_pe = pick(req, m_ptr);
        m_busy = 1;
      end
    end else if (!m_ready_word) begin
      m_ready_word = 1;
    end else if (rdy) begin
      m_cnt = m_cnt + 1'b1;
      m_ptr = (m_pe + 1) % N;
      c = req & ~(N'(1) << m_pe);
      m_ready_word = 0;
      if (c != '0) m_pe = pick(c, m_ptr);
      else m_busy = 0;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 10) begin
      step('0, '1, 1'b0, 1'b0);
      k++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (gq.size() < n && k < budget) begin
      step('0, '1, 1'b1, 1'b0);
      k++;
    end
  endtask

  int          k;
  logic [31:0] d0;

  initial begin
    for (int i = 0; i < N; i++) pe_word[i] = $urandom;
    rst = 1'b1; req = '0; out_ready = 1'b0; g_last = '0;
    m_busy = 0; m_ready_word = 0; m_pe = 0; m_ptr = 0; m_cnt = '0;

    // Reset then idle
    step('0, '1, 1'b0, 1'b1);
    step('0, '1, 1'b0, 1'b1);
    repeat (10) step('0, '1, 1'b0, 1'b0);
    check("idle_cnt", 32'(xfer_count), 32'd0);

    // Single request from PE5
    gq.delete();
    step(16'h0020, '1, 1'b1, 1'b0);
    k = 1;
    while (gq.size() == 0 && k < 10) begin
      step('0, '1, 1'b1, 1'b0);
      k++;
    end
    check("single_lat", 32'(k - 1), 32'd2);
    check("single_pe", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd5);
    step('0, '1, 1'b1, 1'b0);
    check("single_cnt", 32'(xfer_count), 32'd1);

    // Full contention from a fresh pointer
    step('0, '0, 1'b0, 1'b1);
    gq.delete();
    repeat (36) step(16'hFFFF, '1, 1'b1, 1'b0);
    check("cont_ngrants", 32'(gq.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      check("cont_order", (gq.size() > i) ? 32'(gq[i]) : 32'hFFFF, 32'(i % N));
    check("cont_cnt", 32'(xfer_count), 32'd17);
    step('0, '0, 1'b0, 1'b1);

    // Backpressure on PE3
    step(16'h0008, '1, 1'b0, 1'b0);
    wait_valid("bp_valid");
    d0 = mux_q;
    gq.delete();
    repeat (5) begin
      step('0, '1, 1'b0, 1'b0);
      check("bp_sel", 32'(sel), 32'd3);
      check("bp_data", mux_q, d0);
      check("bp_vhold", 32'(out_valid), 32'd1);
    end
    check("bp_nogrant", 32'(gq.size()), 32'd0);
    step('0, '1, 1'b1, 1'b0);
    check("bp_grant", 32'(grant), 32'h0008);
    step('0, '1, 1'b1, 1'b0);
    check("bp_grant_once", 32'(grant), 32'd0);

    // Pointer wrap and masking of the just-served PE15
    gq.delete();
    step(16'h4000, '1, 1'b1, 1'b0);
    wait_grants(1, 10);
    gq.delete();
    step(16'h8001, '1, 1'b1, 1'b0);
    wait_grants(2, 12);
    check("wrap_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd15);
    check("wrap_second", (gq.size() > 1) ? 32'(gq[1]) : 32'hFFFF, 32'd0);

    // Reset in the middle of serving PE7
    step(16'h0080, '1, 1'b0, 1'b0);
    wait_valid("rst_mid_valid");
    check("rst_mid_sel", 32'(sel), 32'd7);
    gq.delete();
    step('0, '1, 1'b1, 1'b1);
    check("rst_nogrant", 32'(grant), 32'd0);
    step('0, '1, 1'b1, 1'b0);
    check("rst_valid_low", 32'(out_valid), 32'd0);
    wait_grants(1, 10);
    check("rst_reserve", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd7);
    step('0, '0, 1'b0, 1'b1);

    // Random traffic with occasional resets
    for (int t = 0; t < 800; t++) begin
      step(($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0, '1,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
